// File: rtl/led_frame_buffer.sv
// Double-buffered 2-colour 8x8 frame store feeding the LED matrix scanner.
// Front/back banks swap only on a scanner frame boundary, then the new back is refilled.
module led_frame_buffer #(
    parameter int unsigned NUM_COLORS = 2,
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned ROW_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             wr_color,
    input  logic [2:0]       wr_row,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             clear_req,
    input  logic             commit_req,
    output logic             busy,
    output logic             swap_done,
    input  logic             frame_end,
    input  logic             rd_color,
    input  logic [2:0]       rd_row,
    output logic [ROW_W-1:0] rd_data
);

    localparam int unsigned Entries = 2 * NUM_COLORS * NUM_ROWS;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StSwapWait,
        StCopy
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             fb_sel_q, fb_sel_d;
    logic             pending_q, pending_d;
    logic [ROW_W-1:0] rd_data_q;

    // Entry address is {bank, colour, row}.
    logic [ROW_W-1:0] mem_q [Entries];
    logic             mem_we;
    logic [4:0]       mem_waddr;
    logic [ROW_W-1:0] mem_wdata;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fb_sel_d  = fb_sel_q;
        pending_d = pending_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (state_q)
            StIdle: begin
                if (wr_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = {~fb_sel_q, wr_color, wr_row};
                    mem_wdata = wr_data;
                end
                if (clear_req) begin
                    state_d   = StClear;
                    idx_d     = 4'd0;
                    pending_d = commit_req;
                end else if (commit_req) begin
                    state_d = StSwapWait;
                end
            end
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = {~fb_sel_q, idx_q};
                if (commit_req) pending_d = 1'b1;
                if (idx_q == 4'd15) begin
                    idx_d   = 4'd0;
                    state_d = (pending_q || commit_req) ? StSwapWait : StIdle;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StSwapWait: begin
                if (frame_end) begin
                    fb_sel_d  = ~fb_sel_q;
                    pending_d = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = StCopy;
                end
            end
            StCopy: begin
                // fb_sel has already toggled, so this copies new front into new back.
                mem_we    = 1'b1;
                mem_waddr = {~fb_sel_q, idx_q};
                mem_wdata = mem_q[{fb_sel_q, idx_q}];
                if (idx_q == 4'd15) begin
                    idx_d   = 4'd0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= 4'd0;
            fb_sel_q  <= 1'b0;
            pending_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fb_sel_q  <= fb_sel_d;
            pending_q <= pending_d;
            rd_data_q <= mem_q[{fb_sel_q, rd_color, rd_row}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Entries; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy      = (state_q != StIdle);
    assign wr_ready  = ~busy;
    assign swap_done = (state_q == StCopy) && (idx_q == 4'd0);
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed self-checking bench for led_frame_buffer.
module tb_led_frame_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_color = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       clear_req = 1'b0;
    logic       commit_req = 1'b0;
    logic       busy;
    logic       swap_done;
    logic       frame_end = 1'b0;
    logic       rd_color = 1'b0;
    logic [2:0] rd_row = 3'd0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    led_frame_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_color   (wr_color),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .commit_req (commit_req),
        .busy       (busy),
        .swap_done  (swap_done),
        .frame_end  (frame_end),
        .rd_color   (rd_color),
        .rd_row     (rd_row),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic c, input logic [2:0] r, input logic [7:0] exp, input string tag);
        rd_color = c;
        rd_row   = r;
        tick();
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic wr(input logic c, input logic [2:0] r, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_color = c;
        wr_row   = r;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    // Pulses frame_end, then ticks until busy falls; n = ticks from frame_end assertion.
    task automatic swap_and_wait(output int n, output int sd_cnt);
        n = 0;
        sd_cnt = 0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        n = 1;
        while (busy && n < 200) begin
            if (swap_done) sd_cnt++;
            tick();
            n++;
        end
        if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int sd;

        // Reset state
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_swap_done", {31'd0, swap_done}, 32'd0);
        check("reset_rd_data", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Write then commit
        wr(1'b0, 3'd3, 8'hA5);
        wr(1'b1, 3'd7, 8'hFF);
        pulse_commit();
        check("sw_busy", {31'd0, busy}, 32'd1);
        rd_color = 1'b0;
        rd_row   = 3'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sw_hold_rd", {24'd0, rd_data}, 32'd0);
            check("sw_hold_busy", {31'd0, busy}, 32'd1);
        end
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("swap_cycle_old_data", {24'd0, rd_data}, 32'd0);
        check("swap_done_hi", {31'd0, swap_done}, 32'd1);
        tick();
        check("new_front_red3", {24'd0, rd_data}, 32'hA5);
        check("swap_done_lo", {31'd0, swap_done}, 32'd0);
        n = 2;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("busy_drop_latency", n, 32'd17);
        rd(1'b1, 3'd7, 8'hFF, "green7");

        // Copy-back; frame_end coincident with commit must be ignored
        wr(1'b0, 3'd0, 8'h01);
        commit_req = 1'b1;
        frame_end  = 1'b1;
        tick();
        commit_req = 1'b0;
        frame_end  = 1'b0;
        rd(1'b0, 3'd0, 8'h00, "fe_with_commit_ignored");
        check("fe_with_commit_busy", {31'd0, busy}, 32'd1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        commit_req = 1'b1;   // commit during COPY: not queued
        tick();
        commit_req = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("copy_idle", {31'd0, busy}, 32'd0);
        rd(1'b0, 3'd3, 8'hA5, "copyback_red3");
        rd(1'b0, 3'd0, 8'h01, "copyback_red0");
        tick();
        check("no_second_swap", {31'd0, busy}, 32'd0);

        // Clear + commit with backpressured write held throughout
        clear_req  = 1'b1;
        commit_req = 1'b1;
        tick();
        clear_req  = 1'b0;
        commit_req = 1'b0;
        wr_valid = 1'b1;
        wr_color = 1'b0;
        wr_row   = 3'd5;
        wr_data  = 8'h3C;
        check("clear_wr_ready", {31'd0, wr_ready}, 32'd0);
        rd(1'b0, 3'd3, 8'hA5, "front_during_clear");
        for (int i = 0; i < 15; i++) tick();
        tick();
        check("after_clear_still_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        check("swapwait_busy", {31'd0, busy}, 32'd1);
        swap_and_wait(n, sd);
        check("clear_swap_done_once", sd, 32'd1);
        check("clear_copy_latency", n, 32'd17);
        tick();                 // first IDLE edge accepts the held write
        wr_valid = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++)
                rd(c[0], r[2:0], 8'h00, "cleared_front");
        pulse_commit();
        swap_and_wait(n, sd);
        rd(1'b0, 3'd5, 8'h3C, "held_write_after_commit");
        rd(1'b0, 3'd3, 8'h00, "held_write_red3_clear");

        // Reset mid-COPY
        wr(1'b1, 3'd2, 8'h77);
        pulse_commit();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("midcopy_rst_busy", {31'd0, busy}, 32'd0);
        check("midcopy_rst_rd", {24'd0, rd_data}, 32'd0);
        #4;
        rst_n = 1'b1;
        tick();
        check("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++)
                rd(c[0], r[2:0], 8'h00, "post_rst_sweep");
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_frame_buffer.md
Name: led_frame_buffer

Overview:
- Double-buffered frame store that sits directly upstream of the 8x8 bicolor LED matrix scanner and replaces its fixed, hard-coded frame table.
- A host-side producer (UART/SPI decoder, pattern generator) writes row bytes into a back buffer.
- The scanner reads the front buffer through a registered read port.
- On a commit request, front and back are swapped only at a frame boundary reported by the scanner, so no tearing is visible. The new back buffer is then refilled from the new front buffer.

Parameters:
- NUM_COLORS, 2, colour planes (0 = red, 1 = green); fixed at 2 in this revision.
- NUM_ROWS, 8, rows per plane; fixed at 8 in this revision.
- ROW_W, 8, bits per row byte; bit n drives matrix column n.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_color  in  1  target plane.
- wr_row  in  3  target row.
- wr_data  in  8  row byte.
- clear_req  in  1  single-cycle pulse: zero the back buffer.
- commit_req  in  1  single-cycle pulse: request a swap at the next frame boundary.
- busy  out  1  high in any state other than IDLE.
- swap_done  out  1  one-cycle pulse in the cycle after the swap takes effect.
- frame_end  in  1  scanner pulse marking that the last row/colour of a frame has finished.
- rd_color  in  1  scanner read plane.
- rd_row  in  3  scanner read row.
- rd_data  out  8  front-buffer byte, registered.

Behaviour:
- Storage: 2 banks x 2 colours x 8 rows x 8 bits. fb_sel selects the front bank; the back bank is !fb_sel.
- Reset (async, rst_n=0):
  - all 32 entries = 0; fb_sel = 0; state = IDLE; idx = 0.
  - rd_data = 0, swap_done = 0, busy = 0.
  - wr_ready = 1 from the first clock edge after rst_n rises.
  - Reset mid-operation abandons the operation; no partial swap survives.
- Read port:
  - rd_data <= front[rd_color][rd_row] every cycle, so latency is exactly 1 cycle.
  - The read is independent of all write and commit activity.
  - A read sampled in the swap cycle returns old-front data; the next cycle returns new-front data.
- States:
  - IDLE:
    - wr_ready = 1. An accepted write stores wr_data into back[wr_color][wr_row] on that edge.
    - clear_req -> CLEAR, idx = 0.
    - Otherwise commit_req -> SWAP_WAIT.
    - clear_req && commit_req in the same cycle -> CLEAR, with commit_pending set.
    - A write accepted in the same cycle as clear_req or commit_req is performed. If clear_req is also high, the clear wipes it.
  - CLEAR:
    - wr_ready = 0. Writes zero to back[idx], idx = 0..15 (colour = idx[3], row = idx[2:0]), one entry per cycle, 16 cycles.
    - At idx == 15: if commit_pending, go to SWAP_WAIT; otherwise go to IDLE.
    - clear_req and commit_req arriving during CLEAR: clear_req is ignored; commit_req sets commit_pending.
  - SWAP_WAIT:
    - wr_ready = 0. Waits for frame_end. Only frame_end sampled while already in SWAP_WAIT counts.
    - On frame_end: fb_sel toggles on that edge, commit_pending clears, idx = 0, go to COPY.
    - clear_req and commit_req are ignored here.
  - COPY:
    - wr_ready = 0. Copies the new front into the new back, back[idx] <= front[idx], idx = 0..15, 16 cycles; then go to IDLE.
    - clear_req and commit_req are ignored; commit_req in this state is not queued.
- swap_done: asserted for exactly the first COPY cycle.
- busy: equals (state != IDLE). wr_ready equals !busy.
- idx: 4-bit counter. It wraps 15 -> 0 only on the exit transition; there is no other wrap path.
- Commit with no intervening writes still swaps. Front and back contents are then identical, so the display is unchanged, but swap_done still pulses.
- Minimum commit-to-IDLE time: 1 cycle to enter SWAP_WAIT, the wait for frame_end, then 16 COPY cycles.

Test Plan:
- Reset then read: assert rst_n=0 mid-COPY, release, sweep rd_row 0..7 on both colours -> rd_data = 0x00 one cycle after each address; wr_ready = 1 and busy = 0.
- Write then commit: write red row3 = 0xA5 and green row7 = 0xFF, pulse commit_req, hold frame_end low for 20 cycles.
  - While frame_end is low: rd_data stays 0x00 and busy = 1.
  - Pulse frame_end -> in the next cycle, reading red row3 gives 0xA5 one cycle later; swap_done is high for exactly 1 cycle; busy drops 17 cycles after the frame_end edge.
- Copy-back: after the previous scenario, write red row0 = 0x01 and commit -> after the swap, red row3 still reads 0xA5 and red row0 reads 0x01.
- Clear plus commit in the same cycle, with the front showing 0xA5 -> 16 CLEAR cycles, then SWAP_WAIT; after frame_end every row reads 0x00.
- Backpressure: hold wr_valid=1 with data 0x3C during CLEAR, SWAP_WAIT and COPY -> nothing is written while wr_ready = 0; the write is accepted on the first IDLE cycle and shows only after the next commit.
- Boundary timing:
  - frame_end in the same cycle as commit_req -> ignored; the swap waits for the next frame_end.
  - commit_req during COPY -> no second swap.
  - Read in the swap cycle -> returns old data.
